// File: rtl/afe_reg_seq_pkg.sv
// Shared types and constants for the AFE4403 register-access sequencer.
// Holds the FSM state encoding, the queued command format and the control0 words.
package afe_reg_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SET_RD,
        ST_CLR_RD,
        ST_XFER,
        ST_GAP,
        ST_RESP
    } seq_state_e;

    typedef struct packed {
        logic        rw;
        logic [7:0]  addr;
        logic [23:0] wdata;
    } cmd_t;

    localparam logic [7:0]  AFE_CTRL0_ADDR = 8'h00;
    localparam int          SPI_READ_BIT   = 0;
    localparam logic [7:0]  AFE_DIAG_ADDR  = 8'h30;
    localparam logic [23:0] RD_SET_WORD    = 24'h000001;
    localparam logic [23:0] RD_CLR_WORD    = 24'h000000;

    // Byte idx of a 4-byte frame, MSB first: addr, d[23:16], d[15:8], d[7:0].
    function automatic logic [7:0] frame_byte(input logic [7:0]  addr,
                                              input logic [23:0] data,
                                              input logic [1:0]  idx);
        case (idx)
            2'd0:    return addr;
            2'd1:    return data[23:16];
            2'd2:    return data[15:8];
            default: return data[7:0];
        endcase
    endfunction

endpackage

// File: rtl/afe_reg_seq_cmd_fifo.sv
// Show-ahead command FIFO for the register sequencer; DEPTH must be a power of 2.
// Pointers wrap naturally; push and pop may occur in the same cycle.
module afe_cmd_fifo
    import afe_reg_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  cmd_t                       push_data,
    input  logic                       pop,
    output cmd_t                       head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    cmd_t            mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [LW-1:0]   level_q;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem_q[rd_ptr_q];
    assign level   = level_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/afe_reg_seq.sv
// AFE4403 register-access sequencer: queues read/write commands, frames them for the
// SPI byte engine and keeps control0 SPI_READ in step. Optional watchdog: AFE_REG_SEQ_TIMEOUT_EN.
module afe_reg_seq
    import afe_reg_seq_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int GAP_CYC     = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                       div_clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_rw,
    input  logic [7:0]                 cmd_addr,
    input  logic [23:0]                cmd_wdata,
    output logic                       rsp_valid,
    output logic [7:0]                 rsp_addr,
    output logic [23:0]                rsp_rdata,
    output logic                       rsp_err,
    output logic                       byte_start,
    output logic [7:0]                 byte_tx,
    input  logic                       byte_done,
    input  logic [7:0]                 byte_rx,
    output logic                       cs_n,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;
    cmd_t        fifo_head;
    cmd_t        push_cmd;
    logic [23:0] head_wdata;
    logic        need_clr;
    logic        need_set;

    seq_state_e       state_q;
    logic [1:0]       idx_q;
    logic             rd_mode_q;
    logic             is_cmd_q;
    logic             is_rd_q;
    logic [7:0]       faddr_q;
    logic [23:0]      fdata_q;
    logic [23:0]      rdata_q;
    logic [GAP_W-1:0] gap_q;
    logic             cs_n_q;
    logic             byte_start_q;
    logic [7:0]       byte_tx_q;
    logic             rsp_valid_q;
    logic [7:0]       rsp_addr_q;
    logic [23:0]      rsp_rdata_q;

`ifdef AFE_REG_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_q;
    logic            err_q;
    logic            rsp_err_q;
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign push_cmd = {cmd_rw, cmd_addr, cmd_wdata};

    afe_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (div_clk),
        .rst       (rst),
        .push      (cmd_valid),
        .push_data (push_cmd),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // A write to control0 must never set SPI_READ behind the sequencer's back.
    always_comb begin
        head_wdata = fifo_head.wdata;
        if (fifo_head.addr == AFE_CTRL0_ADDR) head_wdata[SPI_READ_BIT] = 1'b0;
    end

    assign need_clr = rd_mode_q & (fifo_empty | ~fifo_head.rw);
    assign need_set = ~rd_mode_q & ~fifo_empty & fifo_head.rw;
    assign fifo_pop = (state_q == ST_IDLE) & ~fifo_empty & ~need_clr & ~need_set;

    always_ff @(posedge div_clk) begin
        byte_start_q <= 1'b0;
        rsp_valid_q  <= 1'b0;
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            rd_mode_q    <= 1'b1;
            is_cmd_q     <= 1'b0;
            is_rd_q      <= 1'b0;
            gap_q        <= '0;
            cs_n_q       <= 1'b1;
            byte_start_q <= 1'b0;
            byte_tx_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_addr_q   <= '0;
            rsp_rdata_q  <= '0;
`ifdef AFE_REG_SEQ_TIMEOUT_EN
            wd_q         <= '0;
            err_q        <= 1'b0;
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (need_clr || !fifo_empty) begin
                        idx_q        <= '0;
                        cs_n_q       <= 1'b0;
                        byte_start_q <= 1'b1;
                        rdata_q      <= '0;
`ifdef AFE_REG_SEQ_TIMEOUT_EN
                        wd_q         <= '0;
                        err_q        <= 1'b0;
`endif
                        if (need_clr || need_set) begin
                            faddr_q   <= AFE_CTRL0_ADDR;
                            fdata_q   <= need_set ? RD_SET_WORD : RD_CLR_WORD;
                            byte_tx_q <= AFE_CTRL0_ADDR;
                            is_cmd_q  <= 1'b0;
                            is_rd_q   <= 1'b0;
                            state_q   <= need_set ? ST_SET_RD : ST_CLR_RD;
                        end else begin
                            faddr_q   <= fifo_head.addr;
                            fdata_q   <= fifo_head.rw ? 24'h000000 : head_wdata;
                            byte_tx_q <= fifo_head.addr;
                            is_cmd_q  <= 1'b1;
                            is_rd_q   <= fifo_head.rw;
                            state_q   <= ST_XFER;
                        end
                    end
                end
                ST_SET_RD, ST_CLR_RD, ST_XFER: begin
                    if (byte_done) begin
                        if (is_rd_q && idx_q != 2'd0) rdata_q <= {rdata_q[15:0], byte_rx};
                        if (idx_q == 2'd3) begin
                            cs_n_q  <= 1'b1;
                            gap_q   <= '0;
                            state_q <= ST_GAP;
                            if (state_q == ST_SET_RD)      rd_mode_q <= 1'b1;
                            else if (state_q == ST_CLR_RD) rd_mode_q <= 1'b0;
                        end else begin
                            idx_q        <= idx_q + 2'd1;
                            byte_start_q <= 1'b1;
                            byte_tx_q    <= frame_byte(faddr_q, fdata_q, idx_q + 2'd1);
`ifdef AFE_REG_SEQ_TIMEOUT_EN
                            wd_q         <= '0;
`endif
                        end
                    end
`ifdef AFE_REG_SEQ_TIMEOUT_EN
                    // Abandoned frame: SPI_READ state on the AFE is unknown, so force a CLR_RD later.
                    else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                        cs_n_q    <= 1'b1;
                        gap_q     <= '0;
                        state_q   <= ST_GAP;
                        rd_mode_q <= 1'b1;
                        err_q     <= 1'b1;
                        rdata_q   <= '0;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
`endif
                end
                ST_GAP: begin
                    if (gap_q == GAP_W'(GAP_CYC - 1)) begin
                        if (is_cmd_q) begin
                            rsp_valid_q <= 1'b1;
                            rsp_addr_q  <= faddr_q;
                            rsp_rdata_q <= rdata_q;
`ifdef AFE_REG_SEQ_TIMEOUT_EN
                            rsp_err_q   <= err_q;
`endif
                            state_q     <= ST_RESP;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready  = ~fifo_full;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_addr   = rsp_addr_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign byte_start = byte_start_q;
    assign byte_tx    = byte_tx_q;
    assign cs_n       = cs_n_q;
    assign busy       = (state_q != ST_IDLE) | ~fifo_empty;

endmodule
